// File: rtl/walls_pkg.sv
// Shared playfield constants for the breakable-wall map and its burn slots.
// Row r of INIT_WALL_MAP is bit-indexed by column; pillars (odd,odd) and spawn corners stay clear.
package walls_pkg;

  localparam int unsigned GRID_W  = 16;
  localparam int unsigned GRID_H  = 12;
  localparam int unsigned FRAME_W = 4;

  localparam logic [GRID_H-1:0][GRID_W-1:0] INIT_WALL_MAP = {
    16'h0400,  // row 11
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0104,  // row 3
    16'h0028,  // row 2
    16'h0054,  // row 1
    16'h0000   // row 0
  };

  localparam int unsigned INIT_WALL_COUNT = $countones(INIT_WALL_MAP);

  typedef struct packed {
    logic               active;
    logic [3:0]         col;
    logic [3:0]         row;
    logic [FRAME_W-1:0] frame;
  } burn_slot_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last granted index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    idx      = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      idx = PW'((32'(ptr) + k - 1) % NUM_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        ptr_next   = PW'((32'(idx) + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/walls_map_ctrl.sv
// Breakable-wall map owner: arbitrates explosion hits, runs per-frame burn slots,
// and answers per-tile queries from the drawing path.
module walls_map_ctrl #(
  parameter int unsigned GRID_W      = walls_pkg::GRID_W,
  parameter int unsigned GRID_H      = walls_pkg::GRID_H,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned ANIM_FRAMES = 8
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                startOfFrame,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*4-1:0]                req_col,
  input  logic [NUM_REQ*4-1:0]                req_row,
  output logic [NUM_REQ-1:0]                  ack,
  output logic                                hit_wall,
  input  logic [3:0]                          query_col,
  input  logic [3:0]                          query_row,
  output logic                                wall_present,
  output logic                                wall_burning,
  output logic [$clog2(ANIM_FRAMES)-1:0]      burn_frame,
  output logic [$clog2(GRID_W*GRID_H+1)-1:0]  walls_left,
  output logic                                all_cleared
);

  import walls_pkg::*;

  localparam int unsigned FW = $clog2(ANIM_FRAMES);
  localparam int unsigned LW = $clog2(GRID_W*GRID_H+1);
  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(ANIM_FRAMES - 1);

  logic [GRID_H-1:0][GRID_W-1:0] wall_map;
  burn_slot_t                    slots [NUM_SLOTS];

  logic [NUM_REQ-1:0] needs_slot;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [3:0]         rc, rr;
  logic               busy;
  logic               free_avail;
  logic [SW-1:0]      free_idx;
  logic               alloc;
  logic [3:0]         alloc_col, alloc_row;
  logic [LW-1:0]      expire_cnt;

  function automatic logic in_grid(input logic [3:0] c, input logic [3:0] r);
    return (32'(c) < GRID_W) && (32'(r) < GRID_H);
  endfunction

  // A slot is only needed for a live, not-yet-burning wall; everything else acks immediately.
  always_comb begin
    needs_slot = '0;
    rc         = '0;
    rr         = '0;
    busy       = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rc   = req_col[i*4 +: 4];
      rr   = req_row[i*4 +: 4];
      busy = 1'b0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (slots[s].active && slots[s].col == rc && slots[s].row == rr) busy = 1'b1;
      end
      needs_slot[i] = in_grid(rc, rr) && wall_map[rr][rc] && !busy;
    end

    free_avail = 1'b0;
    free_idx   = '0;
    for (int unsigned s = NUM_SLOTS; s > 0; s--) begin
      if (!slots[s-1].active) begin
        free_avail = 1'b1;
        free_idx   = SW'(s - 1);
      end
    end

    eligible = req & ~ack & (~needs_slot | {NUM_REQ{free_avail}});
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (resetN),
    .req   (eligible),
    .grant (grant)
  );

  always_comb begin
    alloc     = |(grant & needs_slot);
    alloc_col = '0;
    alloc_row = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alloc_col = req_col[i*4 +: 4];
        alloc_row = req_row[i*4 +: 4];
      end
    end

    expire_cnt = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (startOfFrame && slots[s].active && slots[s].frame == LAST_FRAME)
        expire_cnt = expire_cnt + LW'(1);
    end
  end

  // Descending scan so the lowest matching slot supplies the frame.
  always_comb begin
    wall_present = in_grid(query_col, query_row) && wall_map[query_row][query_col];
    wall_burning = 1'b0;
    burn_frame   = '0;
    for (int unsigned s = NUM_SLOTS; s > 0; s--) begin
      if (slots[s-1].active && slots[s-1].col == query_col && slots[s-1].row == query_row) begin
        wall_burning = 1'b1;
        burn_frame   = slots[s-1].frame[FW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wall_map <= INIT_WALL_MAP;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) slots[s] <= '0;
      walls_left  <= LW'(INIT_WALL_COUNT);
      ack         <= '0;
      hit_wall    <= 1'b0;
      all_cleared <= 1'b0;
    end else begin
      ack      <= grant;
      hit_wall <= alloc;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (startOfFrame && slots[s].active) begin
          if (slots[s].frame == LAST_FRAME) begin
            slots[s].active                      <= 1'b0;
            wall_map[slots[s].row][slots[s].col] <= 1'b0;
          end else begin
            slots[s].frame <= slots[s].frame + FRAME_W'(1);
          end
        end
      end
      if (alloc) begin
        slots[free_idx] <= '{active: 1'b1, col: alloc_col, row: alloc_row, frame: '0};
      end
      walls_left  <= (walls_left > expire_cnt) ? walls_left - expire_cnt : '0;
      all_cleared <= (walls_left == '0);
    end
  end

endmodule
